// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, WRITE, FILL, DONE)
//   - owner_e     : which cache owns the current fill (I or D)
//   - block geometry constants and a helper that forms a word address
//     inside a block.
package mem_arb_pkg;

    localparam int MEM_LAT           = 4;   // mem_en (read) to mem_rvalid, in cycles
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    localparam logic [WORD_IDX_BITS-1:0] LAST_WORD_IDX =
        WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    // Clears the byte offset inside a block.
    localparam logic [ADDR_W-1:0] BLOCK_MASK =
        {{(ADDR_W-BLOCK_OFFSET_BITS){1'b1}}, {BLOCK_OFFSET_BITS{1'b0}}};

    // Clears the byte-within-word bit.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Byte address of word idx inside the block starting at blk.
    // blk must already be block-aligned.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0]        blk,
        input logic [WORD_IDX_BITS-1:0] idx
    );
        return blk | {{(ADDR_W-BLOCK_OFFSET_BITS){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the cache-side request signals and the
// memory-side bus of the arbiter.
//   Cache side : i_req/i_addr, d_req/d_we/d_addr/d_wdata in;
//                fill_data/fill_word/i_fill_we/d_fill_we, i_done/d_done,
//                busy out.
//   Memory side: mem_en/mem_wr/mem_addr/mem_wdata out;
//                mem_rdata/mem_rvalid in.
//
// Handshake: a requester raises *_req with stable address/data and holds
// it until the matching *_done pulse (one cycle). The request is sampled
// only when the arbiter is idle; after the grant, further changes to the
// request (including dropping it) are ignored until done. There is no
// backpressure on the memory side: every mem_en is accepted, and each
// read returns exactly once, MEM_LAT cycles later, on mem_rvalid.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                     i_req;
    logic [ADDR_W-1:0]        i_addr;
    logic                     d_req;
    logic                     d_we;
    logic [ADDR_W-1:0]        d_addr;
    logic [DATA_W-1:0]        d_wdata;

    logic                     mem_en;
    logic                     mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_rvalid;

    logic [DATA_W-1:0]        fill_data;
    logic [WORD_IDX_BITS-1:0] fill_word;
    logic                     i_fill_we;
    logic                     d_fill_we;
    logic                     i_done;
    logic                     d_done;
    logic                     busy;

    // Arbiter side.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_done, d_done, busy
    );

    // Environment side (caches + memory).
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_done, d_done, busy
    );

endinterface

// File: rtl/mem_arbiter_fill_counter.sv
// fill_counter: issue and return word counters for one block fill.
//   clk, rst_n        : clock, async active-low reset
//   clr               : zero both counters (at grant)
//   issue_inc/ret_inc : advance the issue / return counter
//   issue_cnt/ret_cnt : current word indices
//   issue_last/ret_last: counter is at the last word of the block
module fill_counter
    import mem_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     issue_inc,
    input  logic                     ret_inc,
    output logic [WORD_IDX_BITS-1:0] issue_cnt,
    output logic [WORD_IDX_BITS-1:0] ret_cnt,
    output logic                     issue_last,
    output logic                     ret_last
);

    logic [WORD_IDX_BITS-1:0] issue_q, issue_d;
    logic [WORD_IDX_BITS-1:0] ret_q, ret_d;

    always_comb begin
        issue_d = issue_q;
        ret_d   = ret_q;
        if (clr) begin
            issue_d = '0;
            ret_d   = '0;
        end else begin
            if (issue_inc) issue_d = issue_q + 1'b1;
            if (ret_inc)   ret_d   = ret_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            issue_q <= issue_d;
            ret_q   <= ret_d;
        end
    end

    assign issue_cnt  = issue_q;
    assign ret_cnt    = ret_q;
    assign issue_last = (issue_q == LAST_WORD_IDX);
    assign ret_last   = (ret_q == LAST_WORD_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between the I-cache fill
// path and the D-cache fill/write-through path.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_arbiter_if.master (cache requests, memory bus,
//                fill return, done pulses, busy)
//   dbg_state  : current FSM state
// D requests win over I requests. A fill streams eight pipelined reads and
// forwards each returned word to the owning cache; a write is one strobe.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus,
    output arb_state_e    dbg_state
);

    arb_state_e               state_q, state_d;
    owner_e                   owner_q, owner_d;
    logic [ADDR_W-1:0]        blk_q, blk_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic                     i_done_q, i_done_d;
    logic                     d_done_q, d_done_d;
    logic                     busy_q, busy_d;

    logic                     cnt_clr;
    logic                     issue_inc;
    logic                     ret_inc;
    logic [WORD_IDX_BITS-1:0] issue_cnt;
    logic [WORD_IDX_BITS-1:0] ret_cnt;
    logic                     issue_last;
    logic                     ret_last;
    logic [WORD_IDX_BITS-1:0] next_idx;
    logic                     ret_valid;

    fill_counter u_fill_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .issue_inc  (issue_inc),
        .ret_inc    (ret_inc),
        .issue_cnt  (issue_cnt),
        .ret_cnt    (ret_cnt),
        .issue_last (issue_last),
        .ret_last   (ret_last)
    );

    // Returned words only count while a fill is in flight; stray or late
    // mem_rvalid pulses in any other state are dropped here.
    assign ret_valid = (state_q == ST_FILL) && bus.mem_rvalid;

    // issue_cnt is the index of the read currently on the bus.
    assign next_idx = issue_cnt + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        blk_d       = blk_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        cnt_clr     = 1'b0;
        issue_inc   = 1'b0;
        ret_inc     = ret_valid;

        unique case (state_q)
            ST_IDLE: begin
                // Strobes are registered, so the first memory access is
                // loaded here and appears in the cycle after the grant.
                if (bus.d_req && bus.d_we) begin
                    state_d     = ST_WRITE;
                    owner_d     = OWN_D;
                    blk_d       = bus.d_addr & WORD_MASK;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = bus.d_addr & WORD_MASK;
                    mem_wdata_d = bus.d_wdata;
                end else if (bus.d_req || bus.i_req) begin
                    state_d    = ST_FILL;
                    owner_d    = bus.d_req ? OWN_D : OWN_I;
                    blk_d      = (bus.d_req ? bus.d_addr : bus.i_addr) & BLOCK_MASK;
                    mem_en_d   = 1'b1;
                    mem_addr_d = blk_d;
                    cnt_clr    = 1'b1;
                end
            end

            ST_WRITE: begin
                state_d  = ST_DONE;
                d_done_d = 1'b1;
            end

            ST_FILL: begin
                if (mem_en_q && !issue_last) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = word_addr(blk_q, next_idx);
                    issue_inc  = 1'b1;
                end
                if (ret_valid && ret_last) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_I) i_done_d = 1'b1;
                    else                  d_done_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            blk_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            blk_q       <= blk_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Returned data is forwarded in the same cycle it arrives; it is zeroed
    // when not part of a fill so the cache never sees stray read data.
    assign bus.fill_data = ret_valid ? bus.mem_rdata : '0;
    assign bus.fill_word = ret_cnt;
    assign bus.i_fill_we = ret_valid && (owner_q == OWN_I);
    assign bus.d_fill_we = ret_valid && (owner_q == OWN_D);

    assign bus.i_done = i_done_q;
    assign bus.d_done = d_done_q;
    assign bus.busy   = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared unified main memory between the I-cache miss path and the D-cache miss/write path of the 16-bit pipelined CPU.
- Accepts block-fill requests from either cache and single-word write-through stores from the D side.
- Issues pipelined reads to the fixed-latency memory and routes returned words back to the winning cache with word index and a completion pulse.
- Sits between both caches and the memory model, inside cpu.

Parameters:
- MEM_LAT, 4: memory read latency in cycles, from mem_en to mem_rvalid.
- WORDS_PER_BLOCK, 8: words per cache block (16-byte block, 16-bit words).
- ADDR_W, 16: byte address width.
- DATA_W, 16: data word width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  1  I-cache fill request; held until i_done.
- i_addr  in  16  I miss byte address; bits [3:0] ignored.
- d_req  in  1  D request; held until d_done.
- d_we  in  1  with d_req: 1 = single-word write, 0 = block fill.
- d_addr  in  16  D byte address; bits [3:0] ignored for fill, bit 0 ignored for write.
- d_wdata  in  16  write data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1 = write.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  write data to memory.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read data valid, MEM_LAT cycles after a read strobe.
- fill_data  out  16  returned word (mem_rdata passed through).
- fill_word  out  3  word index within the block.
- i_fill_we  out  1  write fill_data into the I-cache.
- d_fill_we  out  1  write fill_data into the D-cache.
- i_done  out  1  one-cycle pulse, I transaction complete.
- d_done  out  1  one-cycle pulse, D transaction complete.
- busy  out  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, WRITE, FILL, DONE.
- Reset (async): state IDLE; issue and return counters 0; owner cleared; every output 0.
- Arbitration in IDLE, sampled at the rising edge, fixed D priority:
  - d_req && d_we → WRITE.
  - d_req && !d_we → FILL, owner D.
  - else i_req → FILL, owner I.
  - At grant, latch the address (block-aligned for fill) and d_wdata.
- WRITE (1 cycle): mem_en = mem_wr = 1, mem_addr = latched address with bit 0 cleared, mem_wdata = latched data. Next state DONE.
- FILL issue: for issue_cnt 0..7 on consecutive cycles, mem_en = 1, mem_wr = 0, mem_addr = {blk[15:4], issue_cnt, 1'b0}. After the 8th issue, mem_en = 0 while remaining in FILL.
- FILL return: every mem_rvalid in FILL drives {i|d}_fill_we = 1 for the owner, with fill_word = ret_cnt and fill_data = mem_rdata; ret_cnt increments. When the 8th word returns, next state is DONE.
- DONE (1 cycle): owner's done = 1, busy = 1. Next state IDLE; a new grant is possible at the following edge.
- Latency with the request sampled at edge 0:
  - Write: mem strobe in cycle 1, d_done in cycle 2.
  - Fill: issues in cycles 1–8, returns in cycles 5–12, done in cycle 13, IDLE in cycle 14.
- mem_rvalid outside FILL is ignored (no fill_we). mem_rvalid arriving after 8 words have returned is ignored.
- Dropping the request mid-transaction has no effect; the transaction completes and done still pulses.
- Losing requester: its request stays pending and is granted on the first IDLE cycle in which no D request is present.
- Same-cycle d_req and i_req: D wins, and I is served right after D's DONE, unless a new d_req is present in that IDLE cycle.
- Reset asserted mid-FILL: immediate return to IDLE, no done pulse; requesters must reissue.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, WRITE, FILL, DONE),
  - the owner encoding (OWN_I, OWN_D),
  - BLOCK_OFFSET_BITS = 4 and WORD_IDX_BITS = 3.
- One sub-module, fill_counter: a 3-bit issue counter and a 3-bit return counter with clear/increment and last-issue/last-return flags. It is instantiated once.

Test Plan:
- Reset then i_req = 1, i_addr = 0x1236 → mem_addr 0x1230, 0x1232, … 0x123E in cycles 1–8; i_fill_we in cycles 5–12 with fill_word 0–7; i_done pulses in cycle 13 only; d_fill_we stays 0.
- d_req = 1, d_we = 1, d_addr = 0x0041, d_wdata = 0xBEEF → cycle 1: mem_en = mem_wr = 1, addr 0x0040, wdata 0xBEEF; d_done in cycle 2; busy low in cycle 3.
- i_req and d_req (fill, 0x2000) rise together → D block filled first, d_done at cycle 13; I fill issues at 0x1230 starting cycle 15; i_done at cycle 27.
- rst_n pulled low in cycle 6 of a D fill → all outputs 0 immediately; no d_done; stray mem_rvalid in cycles 7–10 produce no fill_we; a fresh d_req after release restarts at word 0.
- Memory returns a 9th mem_rvalid after completion, and i_req drops in cycle 3 of a fill → no extra fill_we; i_done still pulses at cycle 13.
